// File: rtl/asrv32_dmem_responder.sv
// asrv32_dmem_responder: wait-state data memory behind a req/ack handshake (in: i_clk i_rst i_req i_wr_en i_addr i_wr_mask i_wdata; out: o_rdata o_ack o_err o_busy)
module asrv32_dmem_responder #(
  parameter int          RAM_DEPTH   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_wr_en,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_wr_mask,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ack,
  output logic        o_err,
  output logic        o_busy
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int WORDS = RAM_DEPTH / 4;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic wr_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0] mask_q;
  logic [31:0] mem [WORDS];
  logic [AW-3:0] idx;
  logic [1:0] lane;
  logic range_err, mask_err, err;
  assign idx = addr_q[AW-1:2];
  assign lane = addr_q[1:0];
  assign range_err = addr_q[31:AW] != BASE_ADDR[31:AW];
  assign mask_err = wr_q && !((mask_q == (4'b0001 << lane)) ||
                              (!lane[0] && mask_q == (4'b0011 << lane)) ||
                              (lane == 2'd0 && mask_q == 4'b1111));
  assign err = range_err || mask_err;
  assign o_busy = state != S_IDLE;
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:   state_n = i_req ? (WAIT_STATES > 0 ? S_WAIT : S_ACCESS) : S_IDLE;
      S_WAIT:   state_n = cnt == 4'd1 ? S_ACCESS : S_WAIT;
      S_ACCESS: state_n = S_DONE;
      default:  state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
      cnt <= 4'd0;
      o_rdata <= 32'd0;
      o_ack <= 1'b0;
      o_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state == S_IDLE ? 4'(WAIT_STATES) : state == S_WAIT ? cnt - 4'd1 : cnt;
      o_rdata <= state == S_ACCESS ? (wr_q || err ? 32'd0 : mem[idx]) : o_rdata;
      o_ack <= state == S_ACCESS;
      o_err <= state == S_ACCESS && err;
    end
  end
  always_ff @(posedge i_clk) begin
    if (state == S_IDLE && i_req) begin
      wr_q <= i_wr_en;
      addr_q <= i_addr;
      mask_q <= i_wr_mask;
      wdata_q <= i_wdata;
    end
    if (state == S_ACCESS && wr_q && !err)
      for (int b = 0; b < 4; b++)
        if (mask_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
  end
endmodule

// File: tb/tb_asrv32_dmem_responder.sv
// tb_asrv32_dmem_responder: scoreboard bench for the wait-state data memory
module tb_asrv32_dmem_responder;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst1, req1, wr1, ack1, err1, busy1;
  logic [31:0] addr1, wdata1, rdata1;
  logic [3:0] mask1;
  logic rst0, req0, wr0, ack0, err0, busy0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [3:0] mask0;
  int total = 0, bad = 0;
  logic [32:0] q1[$], q0[$];
  asrv32_dmem_responder #(.RAM_DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(1)) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_req(req1), .i_wr_en(wr1), .i_addr(addr1),
    .i_wr_mask(mask1), .i_wdata(wdata1), .o_rdata(rdata1), .o_ack(ack1),
    .o_err(err1), .o_busy(busy1));
  asrv32_dmem_responder #(.RAM_DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
    .i_clk(clk), .i_rst(rst0), .i_req(req0), .i_wr_en(wr0), .i_addr(addr0),
    .i_wr_mask(mask0), .i_wdata(wdata0), .o_rdata(rdata0), .o_ack(ack0),
    .o_err(err0), .o_busy(busy0));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic acc(input string tag, input logic wr, input logic [31:0] a,
                     input logic [3:0] m, input logic [31:0] d,
                     input logic [31:0] er, input logic ee);
    logic [32:0] e;
    int n;
    q1.push_back({ee, er});
    @(negedge clk);
    req1 = 1'b1; wr1 = wr; addr1 = a; mask1 = m; wdata1 = d;
    @(posedge clk);
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      chk({tag, "_busy"}, {31'd0, busy1}, 32'd1);
      if (ack1) break;
    end
    req1 = 1'b0;
    chk({tag, "_lat"}, 32'(n), 32'd3);
    e = q1.pop_front();
    chk({tag, "_err"}, {31'd0, err1}, {31'd0, e[32]});
    chk({tag, "_rdata"}, rdata1, e[31:0]);
    @(negedge clk);
    chk({tag, "_idle"}, {30'd0, ack1, busy1}, 32'd0);
  endtask
  initial begin
    logic [32:0] e;
    rst1 = 1'b1; req1 = 1'b0; wr1 = 1'b0; addr1 = 32'd0; mask1 = 4'd0; wdata1 = 32'd0;
    rst0 = 1'b1; req0 = 1'b0; wr0 = 1'b0; addr0 = 32'd0; mask0 = 4'd0; wdata0 = 32'd0;
    repeat (2) @(negedge clk);
    rst1 = 1'b0; rst0 = 1'b0;
    chk("rst_rdata", rdata1, 32'd0);
    chk("rst_flags", {29'd0, ack1, err1, busy1}, 32'd0);
    chk("rst0_flags", {29'd0, ack0, err0, busy0}, 32'd0);
    acc("st10", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'd0, 1'b0);
    acc("ld10", 1'b0, 32'h10, 4'h0, 32'd0, 32'hDEADBEEF, 1'b0);
    acc("st14", 1'b1, 32'h14, 4'hF, 32'h11223344, 32'd0, 1'b0);
    acc("sb17", 1'b1, 32'h17, 4'h8, 32'hAA000000, 32'd0, 1'b0);
    acc("ld14a", 1'b0, 32'h14, 4'h0, 32'd0, 32'hAA223344, 1'b0);
    acc("sh16", 1'b1, 32'h16, 4'hC, 32'h55660000, 32'd0, 1'b0);
    acc("ld17", 1'b0, 32'h17, 4'h0, 32'd0, 32'h55663344, 1'b0);
    acc("ld_oor", 1'b0, 32'h400, 4'h0, 32'd0, 32'd0, 1'b1);
    acc("st_oor", 1'b1, 32'h400, 4'hF, 32'h1, 32'd0, 1'b1);
    acc("st_last", 1'b1, 32'h3FC, 4'hF, 32'hA5A55A5A, 32'd0, 1'b0);
    acc("ld_last", 1'b0, 32'h3FC, 4'h0, 32'd0, 32'hA5A55A5A, 1'b0);
    acc("st20", 1'b1, 32'h20, 4'hF, 32'h0BADCAFE, 32'd0, 1'b0);
    acc("st20_m6", 1'b1, 32'h20, 4'h6, 32'hFFFFFFFF, 32'd0, 1'b1);
    acc("st21_m3", 1'b1, 32'h21, 4'h3, 32'hFFFFFFFF, 32'd0, 1'b1);
    acc("st20_m0", 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 32'd0, 1'b1);
    acc("ld20", 1'b0, 32'h20, 4'h0, 32'd0, 32'h0BADCAFE, 1'b0);
    acc("st30", 1'b1, 32'h30, 4'hF, 32'h12345678, 32'd0, 1'b0);
    @(negedge clk);
    req1 = 1'b1; wr1 = 1'b1; addr1 = 32'h30; mask1 = 4'hF; wdata1 = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    chk("abort_wait_busy", {31'd0, busy1}, 32'd1);
    rst1 = 1'b1;
    #1;
    chk("abort_busy", {30'd0, ack1, busy1}, 32'd0);
    req1 = 1'b0;
    #1 rst1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_noack", {31'd0, ack1}, 32'd0);
    end
    acc("ld30", 1'b0, 32'h30, 4'h0, 32'd0, 32'h12345678, 1'b0);
    @(negedge clk);
    req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h40; mask0 = 4'hF; wdata0 = 32'h01020304;
    repeat (3) q0.push_back({1'b0, 32'd0});
    @(posedge clk);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_ack_c%0d", c), {31'd0, ack0}, {31'd0, c % 3 == 2});
      if (ack0) begin
        e = q0.size() > 0 ? q0.pop_front() : 33'h1_FFFF_FFFF;
        chk($sformatf("b2b_err_c%0d", c), {31'd0, err0}, {31'd0, e[32]});
        chk($sformatf("b2b_rdata_c%0d", c), rdata0, e[31:0]);
      end
    end
    req0 = 1'b0;
    chk("b2b_drained", 32'(q0.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
